// File: rtl/tqvp_bus_host.sv
// Single-transaction bus initiator for the TinyQV peripheral data port.
// Accepts a command, issues one write or read strobe, and returns a response.
module tqvp_bus_host #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic [5:0]  bus_address,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);
    localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]    r_size;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_error;
    logic          r_rsp_timeout;
    logic [5:0]    r_bus_address;
    logic [31:0]   r_bus_wdata;
    logic [1:0]    r_bus_write_n;
    logic [1:0]    r_bus_read_n;
    logic          w_accept;
    logic          w_illegal;

    function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {24'h0, data[7:0]};
            2'b01:   return {16'h0, data[15:0]};
            default: return data;
        endcase
    endfunction

    always_comb begin
        w_accept    = cmd_valid && (r_state == IDLE);
        w_illegal   = (cmd_size == 2'b11)
                   || ((cmd_size == 2'b01) && cmd_addr[0])
                   || ((cmd_size == 2'b10) && (cmd_addr[1:0] != 2'b00));
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_nxt = w_illegal ? RESP : (cmd_write ? WRITE : READ);
            WRITE:   w_state_nxt = RESP;
            READ:    if (bus_ready || (r_cnt == LAST)) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Bus outputs fall back to idle every cycle; only an accept or a continuing READ re-drives them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_size        <= 2'b00;
            r_cnt         <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_bus_address <= '0;
            r_bus_wdata   <= '0;
            r_bus_write_n <= 2'b11;
            r_bus_read_n  <= 2'b11;
        end else begin
            r_bus_address <= '0;
            r_bus_wdata   <= '0;
            r_bus_write_n <= 2'b11;
            r_bus_read_n  <= 2'b11;
            if (w_accept) begin
                r_size        <= cmd_size;
                r_cnt         <= '0;
                r_rsp_rdata   <= '0;
                r_rsp_error   <= w_illegal;
                r_rsp_timeout <= 1'b0;
                if (!w_illegal) begin
                    r_bus_address <= cmd_addr;
                    if (cmd_write) begin
                        r_bus_write_n <= cmd_size;
                        r_bus_wdata   <= size_mask(cmd_size, cmd_wdata);
                    end else begin
                        r_bus_read_n  <= cmd_size;
                    end
                end
            end
            if (r_state == READ) begin
                r_cnt <= r_cnt + CW'(1);
                if (bus_ready) begin
                    r_rsp_rdata <= size_mask(r_size, bus_rdata);
                end else if (r_cnt == LAST) begin
                    r_rsp_timeout <= 1'b1;
                end else begin
                    r_bus_read_n  <= r_size;
                    r_bus_address <= r_bus_address;
                end
            end
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;
    assign bus_address = r_bus_address;
    assign bus_wdata   = r_bus_wdata;
    assign bus_write_n = r_bus_write_n;
    assign bus_read_n  = r_bus_read_n;
endmodule

// File: doc/tqvp_bus_host.md
# tqvp_bus_host

Bus initiator for the TinyQV peripheral data port: it accepts single-transaction commands on a valid/ready interface and drives `address`, write data, `data_write_n` and `data_read_n` into a peripheral. It then collects read data via `data_out`/`data_ready` and returns a response. Its uses are a peripheral test harness, a debug/UART-to-bus bridge, and a DMA-style sequencer sitting in front of any peripheral written to the standard TinyQV peripheral port.

## Interface
- `TIMEOUT`, 64: max READ cycles waiting for `bus_ready` before abort (≥1).
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: host idle, command accepted when both high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_size` in 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
- `cmd_addr` in 6: peripheral address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when both high.
- `rsp_rdata` out 32: read data, zero-extended to size.
- `rsp_error` out 1: illegal size or misaligned; no bus cycle issued.
- `rsp_timeout` out 1: read aborted, no `bus_ready` seen.
- `bus_address` out 6: to peripheral `address`.
- `bus_wdata` out 32: to peripheral `data_in`.
- `bus_write_n` out 2: to peripheral `data_write_n`.
- `bus_read_n` out 2: to peripheral `data_read_n`.
- `bus_rdata` in 32: from peripheral `data_out`.
- `bus_ready` in 1: from peripheral `data_ready`.

## Operation
- FSM states: IDLE, WRITE, READ, RESP. `cmd_ready` = (state == IDLE); `rsp_valid` = (state == RESP).
- IDLE, on accept: latch the command and check it.
  - Error cases: `cmd_size`==11, 16-bit with `addr[0]`=1, or 32-bit with `addr[1:0]`≠0.
  - On error: go to RESP with `rsp_error`=1 and `rsp_rdata`=0; bus outputs untouched.
  - Otherwise: go to WRITE or READ.
- All bus outputs are registered. Idle values: `bus_write_n`=`bus_read_n`=11, `bus_address`=0, `bus_wdata`=0.
- WRITE lasts exactly one cycle.
  - `bus_write_n`=`cmd_size`, `bus_address`=`cmd_addr`.
  - `bus_wdata` = `cmd_wdata` masked to size; unused upper bytes are 0.
  - `bus_ready` is ignored. Next state is RESP with `rsp_rdata`=0.
- READ: `bus_read_n`=`cmd_size` and `bus_address`=`cmd_addr`, held every cycle.
  - If `bus_ready`=1 in a cycle: capture `bus_rdata` masked to size (8 → [7:0], 16 → [15:0], 32 → all; upper bits 0) and go to RESP.
  - An internal counter (width `$clog2(TIMEOUT+1)`) counts READ cycles. If the TIMEOUT-th cycle ends without `bus_ready`: go to RESP with `rsp_timeout`=1, `rsp_rdata`=0.
- On entering RESP, bus outputs return to idle values. RESP holds the response stable until `rsp_ready`, then goes to IDLE.
- Response flags are mutually exclusive. They are cleared at the next command accept.

## Timing
- Cycle 0: accept edge. Cycle 1: bus strobe active. Cycle 2 earliest: `rsp_valid`.
- Write latency is exactly 2 cycles, accept to `rsp_valid`. Read latency is 2 + N cycles, where N is the number of wait cycles with `bus_ready` low.
- Error response: `rsp_valid` in cycle 1; no strobe is ever asserted.
- `bus_write_n`≠11 for exactly one cycle per write. Write and read strobes are never active simultaneously.
- Back-to-back throughput: with `rsp_ready` held high, one command per 3 cycles.
- `bus_ready` in a non-READ state is ignored.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_*`=0, bus outputs at idle values.
- Reset mid-transaction: the transaction is abandoned, strobes are at 11 after the reset edge, and no response is produced.

## Test plan
- Write 32-bit 0xDEADBEEF to addr 0x00 → single cycle: `bus_write_n`=10, `bus_wdata`=0xDEADBEEF, `bus_address`=0; `rsp_valid` 2 cycles after accept, no flags.
- Write 8-bit with `cmd_wdata`=0x12345678 to 0x08 → `bus_write_n`=00, `bus_wdata`=0x00000078 for one cycle.
- 16-bit read at 0x04 with `bus_ready` low for 3 cycles, then high while `bus_rdata`=0xAAAA5555 → `bus_read_n`=01 for 4 cycles, `rsp_rdata`=0x00005555, `rsp_valid` 5 cycles after accept.
- Read with `bus_ready` stuck low, TIMEOUT=64 → `bus_read_n` active for exactly 64 cycles, then `rsp_timeout`=1, `rsp_rdata`=0.
- Illegal cases: size 11, or 32-bit at addr 0x02 → `rsp_error`=1 one cycle after accept, strobes stay 11. `rsp_ready` held low for 5 cycles → response held stable and `cmd_ready`=0 throughout.
- Assert `rst_n`=0 during a READ wait → next cycle strobes are 11, `cmd_ready`=1, `rsp_valid`=0.
